// File: rtl/acorn128_job_scheduler.sv
// acorn128_job_scheduler
// Shares one acorn128_top core among NREQ requesters. A round-robin arbiter
// picks a job. The job's operands are latched, and the core is held in reset
// for RST_CYCLES cycles. Start is then asserted until the core reports ready,
// or until TIMEOUT cycles have passed. The result (or an error) is returned
// on a valid/ready response channel.
module acorn128_job_scheduler #(
  parameter int NREQ       = 2,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_in,
  output logic [NREQ-1:0]      req_ready_out,
  input  logic [NREQ-1:0]      req_encrypt_in,
  input  logic [NREQ*128-1:0]  req_key_in,
  input  logic [NREQ*128-1:0]  req_iv_in,
  input  logic [NREQ*128-1:0]  req_text_in,
  input  logic [NREQ*128-1:0]  req_ad_in,
  input  logic [NREQ*64-1:0]   req_len_in,
  output logic                 core_rst_out,
  output logic                 core_start_out,
  output logic                 core_encrypt_out,
  output logic [127:0]         core_key_out,
  output logic [127:0]         core_iv_out,
  output logic [127:0]         core_pt_out,
  output logic [127:0]         core_ct_out,
  output logic [127:0]         core_ad_out,
  output logic [63:0]          core_len_out,
  input  logic [127:0]         core_ct_in,
  input  logic [127:0]         core_pt_in,
  input  logic [127:0]         core_tag_in,
  input  logic                 core_ready_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [IDW-1:0]       resp_id_out,
  output logic [127:0]         resp_data_out,
  output logic [127:0]         resp_tag_out,
  output logic                 resp_err_out,
  output logic                 busy_out
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE_RST,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           enc_q, enc_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   iv_q, iv_d;
  logic [127:0]   text_q, text_d;
  logic [127:0]   ad_q, ad_d;
  logic [63:0]    len_q, len_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   tag_q, tag_d;
  logic           err_q, err_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  int             cand;
  logic           accept;

  // Round-robin search: first pending requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid_in[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  // Handshake and core control outputs; everything is parked while reset is low.
  always_comb begin
    accept         = rst && (state_q == S_IDLE) && gnt_found;
    req_ready_out  = '0;
    if (accept) req_ready_out[gnt_idx] = 1'b1;
    core_rst_out   = !rst || (state_q != S_WAIT);
    core_start_out = rst && (state_q == S_WAIT);
    resp_valid_out = rst && (state_q == S_RESP);
    busy_out       = rst && (state_q != S_IDLE);
  end

  // Operand and response outputs come straight from the latched registers.
  always_comb begin
    core_encrypt_out = enc_q;
    core_key_out     = key_q;
    core_iv_out      = iv_q;
    core_pt_out      = enc_q ? text_q : 128'd0;
    core_ct_out      = enc_q ? 128'd0 : text_q;
    core_ad_out      = ad_q;
    core_len_out     = len_q;
    resp_id_out      = gid_q;
    resp_data_out    = data_q;
    resp_tag_out     = tag_q;
    resp_err_out     = err_q;
  end

  // Job sequencing: accept, reset the core, wait for ready or timeout, respond.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    enc_d     = enc_q;
    key_d     = key_q;
    iv_d      = iv_q;
    text_d    = text_q;
    ad_d      = ad_q;
    len_d     = len_q;
    data_d    = data_q;
    tag_d     = tag_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gid_d     = gnt_idx;
          enc_d     = req_encrypt_in[gnt_idx];
          key_d     = req_key_in[gnt_idx*128 +: 128];
          iv_d      = req_iv_in[gnt_idx*128 +: 128];
          text_d    = req_text_in[gnt_idx*128 +: 128];
          ad_d      = req_ad_in[gnt_idx*128 +: 128];
          len_d     = req_len_in[gnt_idx*64 +: 64];
          rst_cnt_d = '0;
          state_d   = S_CORE_RST;
        end
      end
      S_CORE_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (core_ready_in) begin
          data_d  = enc_q ? core_ct_in : core_pt_in;
          tag_d   = core_tag_in;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          data_d  = '0;
          tag_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          rr_d    = (gid_q == ID_LAST) ? '0 : gid_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      gid_q     <= '0;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      enc_q     <= 1'b0;
      key_q     <= '0;
      iv_q      <= '0;
      text_q    <= '0;
      ad_q      <= '0;
      len_q     <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      enc_q     <= enc_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      text_q    <= text_d;
      ad_q      <= ad_d;
      len_q     <= len_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_acorn128_job_scheduler.sv
// Testbench for acorn128_job_scheduler with a behavioural core stub.
module tb_acorn128_job_scheduler;

  localparam int NREQ = 3;
  localparam int RSTC = 2;
  localparam int TOUT = 64;
  localparam int IDW  = 2;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STICKY = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid_in;
  logic [NREQ-1:0]     req_ready_out;
  logic [NREQ-1:0]     req_encrypt_in;
  logic [NREQ*128-1:0] req_key_in, req_iv_in, req_text_in, req_ad_in;
  logic [NREQ*64-1:0]  req_len_in;
  logic                core_rst_out, core_start_out, core_encrypt_out;
  logic [127:0]        core_key_out, core_iv_out, core_pt_out, core_ct_out, core_ad_out;
  logic [63:0]         core_len_out;
  logic [127:0]        core_ct_in, core_pt_in, core_tag_in;
  logic                core_ready_in;
  logic                resp_valid_out, resp_ready_in;
  logic [IDW-1:0]      resp_id_out;
  logic [127:0]        resp_data_out, resp_tag_out;
  logic                resp_err_out, busy_out;

  int checks = 0;
  int fails  = 0;
  int model_rr = 0;

  logic         slot_enc [NREQ];
  logic [127:0] slot_key [NREQ];
  logic [127:0] slot_iv  [NREQ];
  logic [127:0] slot_text[NREQ];
  logic [127:0] slot_ad  [NREQ];
  logic [63:0]  slot_len [NREQ];

  int   stub_mode = M_NORMAL;
  int   stub_lat  = 4;
  int   stub_cnt  = 0;
  logic stub_done = 1'b0;

  acorn128_job_scheduler #(.NREQ(NREQ), .RST_CYCLES(RSTC), .TIMEOUT(TOUT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_encrypt_in(req_encrypt_in), .req_key_in(req_key_in), .req_iv_in(req_iv_in),
    .req_text_in(req_text_in), .req_ad_in(req_ad_in), .req_len_in(req_len_in),
    .core_rst_out(core_rst_out), .core_start_out(core_start_out),
    .core_encrypt_out(core_encrypt_out), .core_key_out(core_key_out),
    .core_iv_out(core_iv_out), .core_pt_out(core_pt_out), .core_ct_out(core_ct_out),
    .core_ad_out(core_ad_out), .core_len_out(core_len_out),
    .core_ct_in(core_ct_in), .core_pt_in(core_pt_in), .core_tag_in(core_tag_in),
    .core_ready_in(core_ready_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_id_out(resp_id_out), .resp_data_out(resp_data_out), .resp_tag_out(resp_tag_out),
    .resp_err_out(resp_err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // Reference cipher: a self-inverse stand-in for the core's text transform.
  function automatic logic [127:0] refText(input logic [127:0] key, input logic [127:0] iv,
                                           input logic [127:0] text);
    return text ^ key ^ iv;
  endfunction

  function automatic logic [127:0] refTag(input logic enc, input logic [127:0] key,
                                          input logic [127:0] ad, input logic [63:0] len);
    return key ^ ad ^ {len, len} ^ (enc ? 128'd1 : 128'd2);
  endfunction

  function automatic int pickGrant(input logic [NREQ-1:0] m, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Core stub: after reset, counts stub_lat start cycles then raises ready.
  always @(posedge clk) begin
    if (core_rst_out) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else if (core_start_out && !stub_done) begin
      if (stub_cnt == stub_lat - 1) stub_done <= 1'b1;
      else stub_cnt <= stub_cnt + 1;
    end
  end

  // Stub outputs; sticky mode shows stale ready/garbage while the core is in reset.
  always_comb begin
    core_ready_in = 1'b0;
    if (stub_mode != M_NEVER)
      core_ready_in = stub_done || (stub_mode == M_STICKY && core_rst_out);
    core_ct_in  = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;
    core_pt_in  = 128'hC0FF_EE00_C0FF_EE00_C0FF_EE00_C0FF_EE00;
    core_tag_in = 128'h5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5;
    if (stub_done) begin
      core_ct_in  = refText(core_key_out, core_iv_out, core_pt_out);
      core_pt_in  = refText(core_key_out, core_iv_out, core_ct_out);
      core_tag_in = refTag(core_encrypt_out, core_key_out, core_ad_out, core_len_out);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setSlot(input int i, input logic enc, input logic [127:0] key,
                         input logic [127:0] iv, input logic [127:0] text,
                         input logic [127:0] ad, input logic [63:0] len);
    slot_enc[i] = enc; slot_key[i] = key; slot_iv[i] = iv;
    slot_text[i] = text; slot_ad[i] = ad; slot_len[i] = len;
  endtask

  task automatic randomSlot(input int i);
    setSlot(i, 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            64'($urandom_range(1, 128)));
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      req_encrypt_in[i]         = slot_enc[i];
      req_key_in[i*128 +: 128]  = slot_key[i];
      req_iv_in[i*128 +: 128]   = slot_iv[i];
      req_text_in[i*128 +: 128] = slot_text[i];
      req_ad_in[i*128 +: 128]   = slot_ad[i];
      req_len_in[i*64 +: 64]    = slot_len[i];
    end
    req_valid_in = mask;
  endtask

  // One complete job: grant, core reset, wait, response hold, handshake.
  task automatic runJob(input logic [NREQ-1:0] mask, input int mode, input int lat,
                        input int hold, input bit keep);
    int g, n, w, exp_w;
    logic [127:0] e_data, e_tag;
    logic e_err;
    logic [NREQ-1:0] onehot;
    stub_mode = mode;
    stub_lat  = lat;
    applyStimulus(mask);
    g = pickGrant(mask, model_rr);
    n = 0;
    #1;
    while (req_ready_out == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    onehot = '0;
    onehot[g] = 1'b1;
    checkOutput("req_ready", 128'(req_ready_out), 128'(onehot));
    if (n >= 40) return;
    @(negedge clk);
    if (!keep) req_valid_in = '0;
    checkOutput("core_enc", 128'(core_encrypt_out), 128'(slot_enc[g]));
    checkOutput("core_key", core_key_out, slot_key[g]);
    checkOutput("core_iv", core_iv_out, slot_iv[g]);
    checkOutput("core_ad", core_ad_out, slot_ad[g]);
    checkOutput("core_len", 128'(core_len_out), 128'(slot_len[g]));
    checkOutput("core_pt", core_pt_out, slot_enc[g] ? slot_text[g] : 128'd0);
    checkOutput("core_ct", core_ct_out, slot_enc[g] ? 128'd0 : slot_text[g]);
    n = 0;
    while (core_rst_out && n < 20) begin
      @(negedge clk); n++;
    end
    checkOutput("core_rst_cycles", 128'(n), 128'(RSTC));
    checkOutput("core_start", 128'(core_start_out), 128'd1);
    w = 0;
    while (!resp_valid_out && w < 200) begin
      @(negedge clk); w++;
    end
    if (mode == M_NEVER || lat > TOUT - 1) begin
      exp_w = TOUT; e_data = '0; e_tag = '0; e_err = 1'b1;
    end else begin
      exp_w  = lat + 1;
      e_data = refText(slot_key[g], slot_iv[g], slot_text[g]);
      e_tag  = refTag(slot_enc[g], slot_key[g], slot_ad[g], slot_len[g]);
      e_err  = 1'b0;
    end
    checkOutput("wait_cycles", 128'(w), 128'(exp_w));
    if (w >= 200) return;
    checkOutput("resp_id", 128'(resp_id_out), 128'(g));
    checkOutput("resp_data", resp_data_out, e_data);
    checkOutput("resp_tag", resp_tag_out, e_tag);
    checkOutput("resp_err", 128'(resp_err_out), 128'(e_err));
    resp_ready_in = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid_in = '1;
      checkOutput("hold_valid", 128'(resp_valid_out), 128'd1);
      checkOutput("hold_data", resp_data_out, e_data);
      checkOutput("hold_no_grant", 128'(req_ready_out), 128'd0);
      checkOutput("hold_core_rst", 128'(core_rst_out), 128'd1);
    end
    resp_ready_in = 1'b1;
    @(negedge clk);
    resp_ready_in = 1'b0;
    checkOutput("idle_after_hs", 128'(busy_out), 128'd0);
    checkOutput("resp_dropped", 128'(resp_valid_out), 128'd0);
    model_rr = (g + 1) % NREQ;
  endtask

  initial begin
    logic [127:0] ct1;
    logic [NREQ-1:0] m;
    resp_ready_in = 1'b0;
    for (int i = 0; i < NREQ; i++) randomSlot(i);
    rst = 1'b0;
    applyStimulus(3'b011);
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 128'(req_ready_out), 128'd0);
    checkOutput("rst_core_rst", 128'(core_rst_out), 128'd1);
    checkOutput("rst_start", 128'(core_start_out), 128'd0);
    checkOutput("rst_busy", 128'(busy_out), 128'd0);
    checkOutput("rst_resp_valid", 128'(resp_valid_out), 128'd0);
    checkOutput("rst_key", core_key_out, 128'd0);
    rst = 1'b1;

    $display("[TB] two requesters held valid from reset");
    for (int j = 0; j < 4; j++) runJob(3'b011, M_NORMAL, 5, 0, 1'b1);
    req_valid_in = '0;

    $display("[TB] fixed encrypt on requester 0");
    setSlot(0, 1'b1, {16{8'hEE}}, {16{8'hFF}}, {16{8'h66}}, {16{8'hFF}}, 64'd128);
    ct1 = refText({16{8'hEE}}, {16{8'hFF}}, {16{8'h66}});
    runJob(3'b001, M_NORMAL, 7, 0, 1'b0);

    $display("[TB] decrypt with sticky-ready core");
    setSlot(1, 1'b0, {16{8'hEE}}, {16{8'hFF}}, ct1, {16{8'hFF}}, 64'd128);
    runJob(3'b010, M_STICKY, 3, 0, 1'b0);
    checkOutput("decrypt_pt", resp_data_out, {16{8'h66}});

    $display("[TB] timeout and ready-at-limit");
    randomSlot(2);
    runJob(3'b100, M_NEVER, 5, 0, 1'b0);
    randomSlot(0);
    runJob(3'b001, M_NORMAL, TOUT - 1, 0, 1'b0);

    $display("[TB] response held for 10 cycles");
    randomSlot(1);
    runJob(3'b010, M_NORMAL, 4, 10, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NREQ; i++) randomSlot(i);
      m = NREQ'($urandom_range(1, 7));
      runJob(m, ($urandom_range(0, 1) == 1) ? M_STICKY : M_NORMAL,
             int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] reset during WAIT");
    req_valid_in = '0;
    randomSlot(1);
    runJob(3'b010, M_NORMAL, 4, 0, 1'b0);
    randomSlot(2);
    stub_mode = M_NORMAL;
    stub_lat  = 30;
    applyStimulus(3'b100);
    begin
      int n;
      n = 0;
      @(negedge clk);
      req_valid_in = '0;
      while (core_rst_out && n < 20) begin
        @(negedge clk); n++;
      end
      checkOutput("t6_reach_wait", 128'(core_start_out), 128'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("t6_rst_low_core_rst", 128'(core_rst_out), 128'd1);
      @(negedge clk);
      rst = 1'b1;
      checkOutput("t6_busy", 128'(busy_out), 128'd0);
      checkOutput("t6_core_rst", 128'(core_rst_out), 128'd1);
      n = 0;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (resp_valid_out) n++;
      end
      checkOutput("t6_no_resp", 128'(n), 128'd0);
    end
    model_rr = 0;
    for (int i = 0; i < NREQ; i++) randomSlot(i);
    runJob(3'b101, M_NORMAL, 6, 0, 1'b0);

    req_valid_in = '0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
